// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The FSM state encoding, the one-hot grant codes and the default widths all live here.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  // One-hot owner of the memory: bit0 = CPU, bit1 = debug/loader port.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DBG  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Winner selection for the data-memory arbiter (purely combinational).
// When both ports request, prio_dbg decides which one wins. When only one
// port requests, that port wins.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       prio_dbg,
  output logic [1:0] gnt
);

  // Produce a one-hot grant for the requesting port, using prio_dbg to break ties.
  always_comb begin
    gnt = GNT_NONE;
    if (cpu_req && dbg_req) begin
      gnt = prio_dbg ? GNT_DBG : GNT_CPU;
    end else if (cpu_req) begin
      gnt = GNT_CPU;
    end else if (dbg_req) begin
      gnt = GNT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (CPU and debug/loader).
// Each access takes a fixed IDLE -> ACCESS -> RESP sequence, so ack follows req by two cycles.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last.
// Without the macro the CPU always wins a tie.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_cpu,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,

  output logic [1:0]        grant
);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [1:0]        pick_gnt;
  logic              prio_dbg;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic prio_dbg_q, prio_dbg_d;

  // Round-robin pointer: after a CPU grant, favour debug; after a debug grant, favour CPU.
  always_comb begin
    prio_dbg_d = prio_dbg_q;
    if (state_q == IDLE && pick_gnt != GNT_NONE) begin
      prio_dbg_d = (pick_gnt == GNT_CPU);
    end
  end

  // Pointer register; it comes out of reset favouring the CPU.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      prio_dbg_q <= 1'b0;
    end else begin
      prio_dbg_q <= prio_dbg_d;
    end
  end

  assign prio_dbg = prio_dbg_q;
`else
  assign prio_dbg = 1'b0;
`endif

  dmem_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .prio_dbg (prio_dbg),
    .gnt      (pick_gnt)
  );

  // Next-state logic: latch the winner in IDLE, run the memory cycle in ACCESS, ack in RESP.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        grant_d  = GNT_NONE;
        mem_we_d = 1'b0;
        if (pick_gnt != GNT_NONE) begin
          grant_d = pick_gnt;
          state_d = ACCESS;
          if (pick_gnt == GNT_CPU) begin
            mem_we_d   = cpu_we;
            mem_addr_d = cpu_addr;
            mem_din_d  = cpu_wdata;
          end else begin
            mem_we_d   = dbg_we;
            mem_addr_d = dbg_addr;
            mem_din_d  = dbg_wdata;
          end
        end
      end
      ACCESS: begin
        state_d  = RESP;
        mem_we_d = 1'b0;
        if (grant_q == GNT_CPU) begin
          cpu_ack_d = 1'b1;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_dout;
          end
        end else if (grant_q == GNT_DBG) begin
          dbg_ack_d = 1'b1;
          if (!mem_we_q) begin
            dbg_rdata_d = mem_dout;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d  = IDLE;
        grant_d  = GNT_NONE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight access without acking it.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign grant     = grant_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL be the data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL be the data width.
REQ-003 clk_cpu  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 cpu_req  input  1  SHALL be the CPU access request; held until cpu_ack.
REQ-006 cpu_we  input  1  SHALL be the CPU write enable (1 = write, 0 = read).
REQ-007 cpu_addr  input  ADDR_W  SHALL be the CPU word address.
REQ-008 cpu_wdata  input  DATA_W  SHALL be the CPU write data.
REQ-009 cpu_ack  output  1  SHALL be a one-cycle completion pulse to the CPU.
REQ-010 cpu_rdata  output  DATA_W  SHALL be the CPU read data, valid with cpu_ack on reads.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata SHALL mirror the cpu_* ports for the debug/loader port.
REQ-012 mem_we  output  1  SHALL be the memory write enable.
REQ-013 mem_addr  output  ADDR_W  SHALL be the memory word address.
REQ-014 mem_din  output  DATA_W  SHALL be the memory write data.
REQ-015 mem_dout  input  DATA_W  SHALL be the memory read data, valid one rising edge after the address is presented.
REQ-016 grant  output  2  SHALL be one-hot owner: bit0 = CPU, bit1 = debug, 00 = idle.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP; the FSM SHALL advance one state per cycle outside IDLE.
REQ-018 In IDLE with any req high, the FSM SHALL latch the winner into grant and register its we/addr/wdata onto mem_we/mem_addr/mem_din, then enter ACCESS.
REQ-019 In IDLE with no req, the FSM SHALL stay in IDLE with grant = 00 and mem_we = 0.
REQ-020 mem_we SHALL be high only during ACCESS, and only for a granted write.
REQ-021 ACCESS SHALL always go to RESP. On that edge the block SHALL capture mem_dout into the winner's rdata (reads only) and assert the winner's ack for exactly the RESP cycle.
REQ-022 RESP SHALL always go to IDLE and clear grant.
REQ-023 Latency SHALL be fixed: ack is seen 2 cycles after the IDLE-cycle req. Back-to-back throughput SHALL be one access per 3 cycles.
REQ-024 The non-granted ack SHALL stay 0. Its rdata SHALL hold its previous value.
REQ-025 rdata SHALL be unchanged by writes.
REQ-026 A req dropped after grant SHALL NOT abort the access. The access completes and ack still pulses.
REQ-027 Inputs from the non-granted port SHALL be ignored until the FSM is back in IDLE.
REQ-028 A req still high in the RESP cycle SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-029 Reset SHALL force state IDLE, grant = 00, mem_we = 0, mem_addr = 0, mem_din = 0, both ack = 0, both rdata = 0, and the round-robin pointer = CPU-favoured.
REQ-030 Reset asserted in ACCESS or RESP SHALL abort the access. mem_we SHALL be 0 from the next edge and no ack SHALL be issued.

Configuration
REQ-031 With macro DMEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL grant the port not served last. The pointer SHALL update on every grant.
REQ-032 Without DMEM_ARB_ROUND_ROBIN_EN, the CPU SHALL always win simultaneous requests and no pointer register SHALL exist.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef (IDLE/ACCESS/RESP), the grant encodings (GNT_NONE, GNT_CPU, GNT_DBG) and the default ADDR_W/DATA_W constants.
REQ-034 Winner selection SHALL be a sub-module dmem_arb_pick: inputs two reqs and the pointer, output one-hot grant; combinational only.

Verification
REQ-035 CPU read: preload mem[0x010] = 0xDEADBEEF, cpu_req = 1, cpu_we = 0, cpu_addr = 0x010 -> cpu_ack at cycle +2 with cpu_rdata = 0xDEADBEEF; dbg_ack = 0.
REQ-036 Debug write then CPU read: dbg writes 0x12345678 to 0x020 -> mem_we high for exactly 1 cycle. A following CPU read of 0x020 -> 0x12345678.
REQ-037 Simultaneous reqs held for 4 accesses, round-robin build -> grant order CPU, DBG, CPU, DBG. Fixed build -> CPU for all 4, dbg starved.
REQ-038 Reset asserted during ACCESS of a write -> no ack; mem_we = 0 next cycle; state IDLE; grant = 00.
REQ-039 cpu_req dropped in the ACCESS cycle -> cpu_ack still pulses once; the next IDLE with no req shows grant = 00.
